// File: rtl/miriscv_prefetch_fetch_unit.sv
// Instruction prefetch unit: pipelines req/gnt/rvalid fetches into a FIFO of
// {pc, instr} pairs; a redirect flushes the FIFO and drops in-flight replies.
module miriscv_prefetch_fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  output logic            instr_req_o,
  input  logic            instr_gnt_i,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_force_f_i,
  input  logic [XLEN-1:0] cu_force_pc_i,
  output logic [XLEN-1:0] fetched_pc_addr_o,
  output logic [XLEN-1:0] fetched_pc_next_addr_o,
  output logic [XLEN-1:0] instr_o,
  output logic            fetch_rvalid_o
);

  localparam int unsigned     PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW   = PW + 1;
  localparam int unsigned     OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned     TW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [XLEN-1:0] WORD = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [OW-1:0]   r_outst;
  logic [OW-1:0]   r_discard;
  logic [XLEN-1:0] r_trk [MAX_OUTSTANDING];
  logic [TW-1:0]   r_trk_rd;
  logic [TW-1:0]   r_trk_wr;

  logic [OW-1:0]   w_live;
  logic [OW-1:0]   w_outst_nxt;
  logic            w_head_vld;
  logic            w_issue;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_head_pc;

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // A FIFO slot is reserved for every live request, so pushes never overflow.
  assign w_live      = r_outst - r_discard;
  assign instr_req_o = arstn_i & ~cu_force_f_i
                     & (32'(r_outst) < MAX_OUTSTANDING)
                     & ((32'(r_count) + 32'(w_live)) < FIFO_DEPTH);
  assign instr_addr_o = r_pc;
  assign w_issue      = instr_req_o & instr_gnt_i;

  assign w_drop      = instr_rvalid_i & ((r_discard != '0) | cu_force_f_i);
  assign w_push      = instr_rvalid_i & ~w_drop;
  assign w_outst_nxt = r_outst + OW'(w_issue) - OW'(instr_rvalid_i);

  // Head fields read as zero while the FIFO is empty.
  assign w_head_vld             = (r_count != '0);
  assign w_head_pc              = w_head_vld ? r_fifo_pc[r_rd_ptr] : '0;
  assign fetch_rvalid_o         = w_head_vld & ~cu_force_f_i;
  assign w_pop                  = fetch_rvalid_o & ~cu_stall_f_i;
  assign fetched_pc_addr_o      = w_head_pc;
  assign fetched_pc_next_addr_o = w_head_vld ? (w_head_pc + WORD) : '0;
  assign instr_o                = w_head_vld ? r_fifo_data[r_rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      r_pc      <= RESET_PC;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
      r_trk_rd  <= '0;
      r_trk_wr  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_trk[i] <= '0;
      end
    end else begin
      r_outst <= w_outst_nxt;

      // Every response still owed at a redirect belongs to the old stream.
      if (cu_force_f_i) begin
        r_discard <= w_outst_nxt;
      end else if (instr_rvalid_i && (r_discard != '0)) begin
        r_discard <= r_discard - OW'(1);
      end

      if (cu_force_f_i) begin
        r_pc <= cu_force_pc_i;
      end else if (w_issue) begin
        r_pc <= r_pc + WORD;
      end

      if (w_issue) begin
        r_trk[r_trk_wr] <= r_pc;
        r_trk_wr        <= trk_inc(r_trk_wr);
      end
      if (instr_rvalid_i) begin
        r_trk_rd <= trk_inc(r_trk_rd);
      end

      if (cu_force_f_i) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]   <= r_trk[r_trk_rd];
          r_fifo_data[r_wr_ptr] <= instr_rdata_i;
          r_wr_ptr              <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Invariant checks; simulation only, no hardware is implied.
  always_ff @(posedge clk_i) begin
    if (arstn_i) begin
      assert (!(instr_rvalid_i && (r_outst == '0)));
      assert ((32'(r_count) + 32'(w_live)) <= FIFO_DEPTH);
      assert (r_discard <= r_outst);
    end
  end

endmodule

// File: tb/tb_miriscv_prefetch_fetch_unit.sv
// Bench for miriscv_prefetch_fetch_unit: directed scenarios plus a random phase,
// scored against a stream-level model of the expected fetch behaviour.
module tb_miriscv_prefetch_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RST_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        arstn_i;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        cu_stall_f_i;
  logic        cu_force_f_i;
  logic [31:0] cu_force_pc_i;
  logic [31:0] fetched_pc_addr_o;
  logic [31:0] fetched_pc_next_addr_o;
  logic [31:0] instr_o;
  logic        fetch_rvalid_o;

  miriscv_prefetch_fetch_unit #(
    .XLEN(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RST_PC)
  ) dut (
    .clk_i                 (clk),
    .arstn_i               (arstn_i),
    .instr_req_o           (instr_req_o),
    .instr_gnt_i           (instr_gnt_i),
    .instr_addr_o          (instr_addr_o),
    .instr_rvalid_i        (instr_rvalid_i),
    .instr_rdata_i         (instr_rdata_i),
    .cu_stall_f_i          (cu_stall_f_i),
    .cu_force_f_i          (cu_force_f_i),
    .cu_force_pc_i         (cu_force_pc_i),
    .fetched_pc_addr_o     (fetched_pc_addr_o),
    .fetched_pc_next_addr_o(fetched_pc_next_addr_o),
    .instr_o               (instr_o),
    .fetch_rvalid_o        (fetch_rvalid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          rdy;
  } req_t;

  // Memory side: granted requests awaiting a response, oldest first.
  req_t        memq[$];
  logic [31:0] pop_log[$];
  logic [31:0] salt;
  int          cyc, epoch, occ, mfifo, n_grant;
  logic [31:0] exp_pc, exp_issue;
  int          gnt_pct, stall_pct, rv_pct, lat_min, lat_max;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Reset the DUT and the model; memory forgets every pre-reset request.
  task automatic do_reset();
    arstn_i        = 1'b0;
    cu_force_f_i   = 1'b0;
    cu_stall_f_i   = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    memq.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk1("rst_req", instr_req_o, 1'b0);
    chk1("rst_fvalid", fetch_rvalid_o, 1'b0);
    chk("rst_pc", fetched_pc_addr_o, 32'h0);
    chk("rst_next_pc", fetched_pc_next_addr_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    arstn_i   = 1'b1;
    epoch++;
    occ       = 0;
    mfifo     = 0;
    n_grant   = 0;
    exp_pc    = RST_PC;
    exp_issue = RST_PC;
    pop_log.delete();
  endtask

  // One clock cycle: draw inputs, check outputs against the model, advance the model.
  task automatic tick();
    logic exp_req, exp_fv, g;
    req_t e;
    instr_gnt_i  = ($urandom_range(1, 100) <= gnt_pct);
    cu_stall_f_i = ($urandom_range(1, 100) <= stall_pct);
    if (memq.size() > 0 && memq[0].rdy <= cyc && $urandom_range(1, 100) <= rv_pct) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(memq[0].addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = $urandom;
    end
    #1;
    exp_req = !cu_force_f_i && (memq.size() < MAX_OUT) && (occ < DEPTH);
    chk1("req", instr_req_o, exp_req);
    if (exp_req) chk("addr", instr_addr_o, exp_issue);
    exp_fv = (mfifo > 0) && !cu_force_f_i;
    chk1("fvalid", fetch_rvalid_o, exp_fv);
    if (exp_fv) begin
      chk("head_pc", fetched_pc_addr_o, exp_pc);
      chk("head_next_pc", fetched_pc_next_addr_o, exp_pc + 32'd4);
      chk("head_instr", instr_o, mem_word(exp_pc));
    end
    g = instr_req_o && instr_gnt_i;
    if (instr_rvalid_i) begin
      e = memq.pop_front();
      if (e.ep == epoch && !cu_force_f_i) mfifo++;
    end
    if (exp_fv && !cu_stall_f_i) begin
      pop_log.push_back(exp_pc);
      mfifo--;
      occ--;
      exp_pc = exp_pc + 32'd4;
    end
    if (g) begin
      memq.push_back('{addr: instr_addr_o, ep: epoch, rdy: cyc + int'($urandom_range(lat_min, lat_max))});
      occ++;
      n_grant++;
      exp_issue = exp_issue + 32'd4;
    end
    if (cu_force_f_i) begin
      epoch++;
      occ       = 0;
      mfifo     = 0;
      exp_pc    = cu_force_pc_i;
      exp_issue = cu_force_pc_i;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic        found;
    logic [31:0] saved;
    salt          = $urandom;
    cyc           = 0;
    epoch         = 0;
    cu_force_pc_i = '0;

    // Back-to-back stream: gnt always, response one cycle after grant.
    gnt_pct = 100; stall_pct = 0; rv_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (12) tick();
    chk("stream_pc0", log_at(0), 32'h0);
    chk("stream_pc1", log_at(1), 32'h4);

    // Stall holds the head; issue stops once the FIFO is spoken for.
    do_reset();
    stall_pct = 100;
    repeat (10) tick();
    chk("stall_grants", 32'(n_grant), 32'd4);
    chk1("stall_req_off", instr_req_o, 1'b0);
    chk1("stall_head_vld", fetch_rvalid_o, 1'b1);
    chk("stall_head_pc", fetched_pc_addr_o, 32'h0);
    stall_pct = 0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) chk("stall_order", log_at(i), 32'(4 * i));

    // Redirect in the cycle 0x10 returns while 0x14 is still outstanding.
    do_reset();
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (memq.size() >= 2 && memq[0].addr == 32'h10 && memq[0].rdy <= cyc) found = 1'b1;
      else tick();
    end
    chk1("force_setup", found, 1'b1);
    pop_log.delete();
    cu_force_f_i  = 1'b1;
    cu_force_pc_i = 32'h200;
    tick();
    cu_force_f_i  = 1'b0;
    repeat (12) tick();
    chk("force_first_pc", log_at(0), 32'h200);

    // Grant withheld: request and address hold steady.
    gnt_pct = 0;
    repeat (3) tick();
    saved = instr_addr_o;
    repeat (5) tick();
    chk1("nognt_req", instr_req_o, 1'b1);
    chk("nognt_addr", instr_addr_o, saved);

    // Address wrap at the top of the space.
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    pop_log.delete();
    cu_force_f_i  = 1'b1;
    cu_force_pc_i = 32'hFFFF_FFF8;
    tick();
    cu_force_f_i  = 1'b0;
    repeat (10) tick();
    found = 1'b0;
    for (int i = 0; i < pop_log.size(); i++) begin
      if (!found && pop_log[i] == 32'hFFFF_FFFC) begin
        found = 1'b1;
        chk("wrap_after", log_at(i + 1), 32'h0);
      end
    end
    chk1("wrap_seen", found, 1'b1);

    // Reset while three entries sit in the FIFO.
    do_reset();
    stall_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (mfifo == 3) found = 1'b1;
    end
    chk1("midrst_fill", found, 1'b1);
    do_reset();
    stall_pct = 0;
    repeat (8) tick();
    chk("midrst_restart", log_at(0), RST_PC);

    // Random traffic with occasional redirects.
    gnt_pct = 70; stall_pct = 30; rv_pct = 70; lat_min = 1; lat_max = 3;
    repeat (1500) begin
      if ($urandom_range(1, 100) <= 3) begin
        cu_force_f_i  = 1'b1;
        cu_force_pc_i = $urandom & 32'hFFFF_FFFC;
      end
      tick();
      cu_force_f_i = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
